// File: rtl/memory_register_write_stage.sv
// Memory-to-register write stage: one pipe register per lane, commits to RF/AL/MSHR.
// Optional perf counters enabled by RSD_MEM_WB_PERF_COUNTER_EN.
module memory_register_write_stage #(
  parameter int LANES  = 2,
  parameter int AL_W   = 6,
  parameter int PREG_W = 7,
  parameter int MSHR_W = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      clear,
  input  logic [LANES-1:0]          inValid,
  input  logic [LANES-1:0]          inRegValid,
  input  logic [LANES*32-1:0]       inData,
  input  logic [LANES*PREG_W-1:0]   inDst,
  input  logic [LANES-1:0]          inWriteReg,
  input  logic [LANES*AL_W-1:0]     inAlPtr,
  input  logic [LANES*2-1:0]        inExecState,
  input  logic [LANES-1:0]          inIsLoad,
  input  logic [LANES-1:0]          inSfMiss,
  input  logic [LANES-1:0]          inHasMshr,
  input  logic [LANES*MSHR_W-1:0]   inMshrId,
  input  logic                      toRecovery,
  input  logic [AL_W-1:0]           flushHead,
  input  logic [AL_W-1:0]           flushTail,
  input  logic                      flushAll,
  output logic [LANES-1:0]          rfWe,
  output logic [LANES*PREG_W-1:0]   rfAddr,
  output logic [LANES*32-1:0]       rfData,
  output logic [LANES-1:0]          alWe,
  output logic [LANES*AL_W-1:0]     alPtr,
  output logic [LANES*2-1:0]        alState,
  output logic [LANES-1:0]          mshrRelease,
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
  output logic [31:0]               perfLoadWb,
  output logic [31:0]               perfSfMiss,
`endif
  output logic [LANES*MSHR_W-1:0]   mshrRelId
);

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES-1:0]        reg_valid_q, reg_valid_d;
  logic [LANES*32-1:0]     data_q, data_d;
  logic [LANES*PREG_W-1:0] dst_q, dst_d;
  logic [LANES-1:0]        write_reg_q, write_reg_d;
  logic [LANES*AL_W-1:0]   al_ptr_q, al_ptr_d;
  logic [LANES*2-1:0]      exec_state_q, exec_state_d;
  logic [LANES-1:0]        is_load_q, is_load_d;
  logic [LANES-1:0]        sf_miss_q, sf_miss_d;
  logic [LANES-1:0]        has_mshr_q, has_mshr_d;
  logic [LANES*MSHR_W-1:0] mshr_id_q, mshr_id_d;

  logic [LANES-1:0]        flush;
  logic [LANES-1:0]        fire;
  logic [LANES-1:0]        ld_miss;
  logic [AL_W-1:0]         ptr;

  // Capture a new op bundle unless the backend stalls
  always_comb begin
    valid_d      = valid_q;
    reg_valid_d  = reg_valid_q;
    data_d       = data_q;
    dst_d        = dst_q;
    write_reg_d  = write_reg_q;
    al_ptr_d     = al_ptr_q;
    exec_state_d = exec_state_q;
    is_load_d    = is_load_q;
    sf_miss_d    = sf_miss_q;
    has_mshr_d   = has_mshr_q;
    mshr_id_d    = mshr_id_q;
    if (!stall) begin
      valid_d      = inValid & ~{LANES{clear}};
      reg_valid_d  = inRegValid;
      data_d       = inData;
      dst_d        = inDst;
      write_reg_d  = inWriteReg;
      al_ptr_d     = inAlPtr;
      exec_state_d = inExecState;
      is_load_d    = inIsLoad;
      sf_miss_d    = inSfMiss;
      has_mshr_d   = inHasMshr;
      mshr_id_d    = inMshrId;
    end
  end

  // Valid bits are the only reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Payload is don't-care while invalid, so it carries no reset
  always_ff @(posedge clk) begin
    reg_valid_q  <= reg_valid_d;
    data_q       <= data_d;
    dst_q        <= dst_d;
    write_reg_q  <= write_reg_d;
    al_ptr_q     <= al_ptr_d;
    exec_state_q <= exec_state_d;
    is_load_q    <= is_load_d;
    sf_miss_q    <= sf_miss_d;
    has_mshr_q   <= has_mshr_d;
    mshr_id_q    <= mshr_id_d;
  end

  // Per-lane flush test against the circular [head, tail) range and commit strobes
  always_comb begin
    flush       = '0;
    fire        = '0;
    ld_miss     = '0;
    ptr         = '0;
    rfWe        = '0;
    alWe        = '0;
    mshrRelease = '0;
    alState     = '0;
    for (int l = 0; l < LANES; l++) begin
      ptr = al_ptr_q[l*AL_W +: AL_W];
      if (flushAll) begin
        flush[l] = 1'b1;
      end else if (toRecovery) begin
        if (flushHead < flushTail)
          flush[l] = (ptr >= flushHead) && (ptr < flushTail);
        else if (flushHead > flushTail)
          flush[l] = (ptr >= flushHead) || (ptr < flushTail);
      end
      fire[l]        = valid_q[l] && !stall && !flush[l];
      ld_miss[l]     = is_load_q[l] && sf_miss_q[l];
      rfWe[l]        = fire[l] && write_reg_q[l] && reg_valid_q[l] && !ld_miss[l];
      alWe[l]        = fire[l];
      mshrRelease[l] = fire[l] && is_load_q[l] && has_mshr_q[l];
      alState[l*2 +: 2] = ld_miss[l] ? 2'b11 : exec_state_q[l*2 +: 2];
    end
  end

  assign rfAddr    = dst_q;
  assign rfData    = data_q;
  assign alPtr     = al_ptr_q;
  assign mshrRelId = mshr_id_q;

`ifdef RSD_MEM_WB_PERF_COUNTER_EN
  logic [31:0] load_wb_q, load_wb_d;
  logic [31:0] sf_cnt_q, sf_cnt_d;

  // Sum load writebacks and fired store-forward-miss loads across lanes
  always_comb begin
    load_wb_d = load_wb_q;
    sf_cnt_d  = sf_cnt_q;
    for (int l = 0; l < LANES; l++) begin
      load_wb_d = load_wb_d + 32'(rfWe[l] && is_load_q[l]);
      sf_cnt_d  = sf_cnt_d + 32'(fire[l] && ld_miss[l]);
    end
  end

  // Wrapping counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_wb_q <= '0;
      sf_cnt_q  <= '0;
    end else begin
      load_wb_q <= load_wb_d;
      sf_cnt_q  <= sf_cnt_d;
    end
  end

  assign perfLoadWb = load_wb_q;
  assign perfSfMiss = sf_cnt_q;
`endif

endmodule

// File: tb/tb_memory_register_write_stage.sv
// Bench for memory_register_write_stage: directed cases plus random stimulus
// checked every cycle against a behavioural op-queue model.
module tb_memory_register_write_stage;
  localparam int LANES  = 2;
  localparam int AL_W   = 6;
  localparam int PREG_W = 7;
  localparam int MSHR_W = 1;
  localparam int AL_N   = 1 << AL_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stall, clear;
  logic [LANES-1:0]        inValid, inRegValid, inWriteReg;
  logic [LANES*32-1:0]     inData;
  logic [LANES*PREG_W-1:0] inDst;
  logic [LANES*AL_W-1:0]   inAlPtr;
  logic [LANES*2-1:0]      inExecState;
  logic [LANES-1:0]        inIsLoad, inSfMiss, inHasMshr;
  logic [LANES*MSHR_W-1:0] inMshrId;
  logic                    toRecovery, flushAll;
  logic [AL_W-1:0]         flushHead, flushTail;
  logic [LANES-1:0]        rfWe, alWe, mshrRelease;
  logic [LANES*PREG_W-1:0] rfAddr;
  logic [LANES*32-1:0]     rfData;
  logic [LANES*AL_W-1:0]   alPtr;
  logic [LANES*2-1:0]      alState;
  logic [LANES*MSHR_W-1:0] mshrRelId;
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
  logic [31:0]             perfLoadWb, perfSfMiss;
  logic [31:0]             m_lwb, m_sfm;
  logic [31:0]             sf_before;
`endif

  int checks = 0;
  int errors = 0;

  memory_register_write_stage #(
    .LANES(LANES), .AL_W(AL_W), .PREG_W(PREG_W), .MSHR_W(MSHR_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear),
    .inValid(inValid), .inRegValid(inRegValid), .inData(inData),
    .inDst(inDst), .inWriteReg(inWriteReg), .inAlPtr(inAlPtr),
    .inExecState(inExecState), .inIsLoad(inIsLoad),
    .inSfMiss(inSfMiss), .inHasMshr(inHasMshr), .inMshrId(inMshrId),
    .toRecovery(toRecovery), .flushHead(flushHead),
    .flushTail(flushTail), .flushAll(flushAll),
    .rfWe(rfWe), .rfAddr(rfAddr), .rfData(rfData),
    .alWe(alWe), .alPtr(alPtr), .alState(alState),
    .mshrRelease(mshrRelease),
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
    .perfLoadWb(perfLoadWb), .perfSfMiss(perfSfMiss),
`endif
    .mshrRelId(mshrRelId)
  );

  always #5 clk = ~clk;

  // Model: the op each lane currently holds
  bit              m_valid [LANES];
  bit              m_regv  [LANES];
  bit              m_wr    [LANES];
  bit              m_ld    [LANES];
  bit              m_sf    [LANES];
  bit              m_hm    [LANES];
  logic [31:0]     m_data  [LANES];
  logic [PREG_W-1:0] m_dst [LANES];
  logic [AL_W-1:0] m_ptr   [LANES];
  logic [1:0]      m_es    [LANES];
  logic [MSHR_W-1:0] m_mid [LANES];

  task automatic chk(input string name, input int l,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got %h expected %h at %0t",
               name, l, act, exp, $time);
    end
  endtask

  // Pointer lies in [head, tail) when its distance from head is below the span
  function automatic bit in_flush(input int l);
    int span, off;
    if (flushAll) return 1'b1;
    if (!toRecovery) return 1'b0;
    span = (int'(flushTail) - int'(flushHead) + AL_N) % AL_N;
    off  = (int'(m_ptr[l]) - int'(flushHead) + AL_N) % AL_N;
    return off < span;
  endfunction

  function automatic bit e_fire(input int l);
    return m_valid[l] && !stall && !in_flush(l);
  endfunction

  function automatic bit e_rfwe(input int l);
    return e_fire(l) && m_wr[l] && m_regv[l] && !(m_ld[l] && m_sf[l]);
  endfunction

  function automatic bit e_rel(input int l);
    return e_fire(l) && m_ld[l] && m_hm[l];
  endfunction

  // Model update on each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) m_valid[l] <= 1'b0;
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
      m_lwb <= 0;
      m_sfm <= 0;
`endif
    end else begin
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
      begin
        int a, b;
        a = 0;
        b = 0;
        for (int l = 0; l < LANES; l++) begin
          a += int'(e_rfwe(l) && m_ld[l]);
          b += int'(e_fire(l) && m_ld[l] && m_sf[l]);
        end
        m_lwb <= m_lwb + 32'(a);
        m_sfm <= m_sfm + 32'(b);
      end
`endif
      if (!stall) begin
        for (int l = 0; l < LANES; l++) begin
          m_valid[l] <= inValid[l] && !clear;
          m_regv[l]  <= inRegValid[l];
          m_wr[l]    <= inWriteReg[l];
          m_ld[l]    <= inIsLoad[l];
          m_sf[l]    <= inSfMiss[l];
          m_hm[l]    <= inHasMshr[l];
          m_data[l]  <= inData[l*32 +: 32];
          m_dst[l]   <= inDst[l*PREG_W +: PREG_W];
          m_ptr[l]   <= inAlPtr[l*AL_W +: AL_W];
          m_es[l]    <= inExecState[l*2 +: 2];
          m_mid[l]   <= inMshrId[l*MSHR_W +: MSHR_W];
        end
      end
    end
  end

  // Compare all outputs against the model mid-cycle
  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      chk("rfWe", l, 32'(rfWe[l]), 32'(e_rfwe(l)));
      chk("alWe", l, 32'(alWe[l]), 32'(e_fire(l)));
      chk("mshrRelease", l, 32'(mshrRelease[l]), 32'(e_rel(l)));
      if (e_rfwe(l)) begin
        chk("rfAddr", l, 32'(rfAddr[l*PREG_W +: PREG_W]), 32'(m_dst[l]));
        chk("rfData", l, rfData[l*32 +: 32], m_data[l]);
      end
      if (e_fire(l)) begin
        chk("alPtr", l, 32'(alPtr[l*AL_W +: AL_W]), 32'(m_ptr[l]));
        chk("alState", l, 32'(alState[l*2 +: 2]),
            (m_ld[l] && m_sf[l]) ? 32'd3 : 32'(m_es[l]));
      end
      if (e_rel(l))
        chk("mshrRelId", l, 32'(mshrRelId[l*MSHR_W +: MSHR_W]), 32'(m_mid[l]));
    end
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
    chk("perfLoadWb", 0, perfLoadWb, m_lwb);
    chk("perfSfMiss", 0, perfSfMiss, m_sfm);
`endif
  end

  task automatic idle();
    stall = 0; clear = 0;
    inValid = '0; inRegValid = '0; inWriteReg = '0;
    inData = '0; inDst = '0; inAlPtr = '0; inExecState = '0;
    inIsLoad = '0; inSfMiss = '0; inHasMshr = '0; inMshrId = '0;
    toRecovery = 0; flushAll = 0; flushHead = '0; flushTail = '0;
  endtask

  task automatic set_lane(input int l, input logic [PREG_W-1:0] dst,
                          input logic [31:0] data, input logic regv,
                          input logic wr, input logic [AL_W-1:0] ptr,
                          input logic [1:0] es, input logic ld,
                          input logic sf, input logic hm,
                          input logic [MSHR_W-1:0] mid);
    inValid[l]    = 1'b1;
    inRegValid[l] = regv;
    inWriteReg[l] = wr;
    inIsLoad[l]   = ld;
    inSfMiss[l]   = sf;
    inHasMshr[l]  = hm;
    inData[l*32 +: 32]         = data;
    inDst[l*PREG_W +: PREG_W]  = dst;
    inAlPtr[l*AL_W +: AL_W]    = ptr;
    inExecState[l*2 +: 2]      = es;
    inMshrId[l*MSHR_W +: MSHR_W] = mid;
  endtask

  task automatic rand_in();
    stall      = ($urandom_range(3) == 0);
    clear      = ($urandom_range(7) == 0);
    toRecovery = ($urandom_range(3) == 0);
    flushAll   = ($urandom_range(15) == 0);
    flushHead  = AL_W'($urandom);
    flushTail  = ($urandom_range(7) == 0) ? flushHead : AL_W'($urandom);
    for (int l = 0; l < LANES; l++) begin
      inValid[l]    = ($urandom_range(3) != 0);
      inRegValid[l] = 1'($urandom);
      inWriteReg[l] = 1'($urandom);
      inIsLoad[l]   = 1'($urandom);
      inSfMiss[l]   = ($urandom_range(3) == 0);
      inHasMshr[l]  = 1'($urandom);
      inData[l*32 +: 32]           = $urandom;
      inDst[l*PREG_W +: PREG_W]    = PREG_W'($urandom);
      inAlPtr[l*AL_W +: AL_W]      = AL_W'($urandom);
      inExecState[l*2 +: 2]        = 2'($urandom);
      inMshrId[l*MSHR_W +: MSHR_W] = MSHR_W'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    #2;
    chk("reset_rfWe", 0, 32'(rfWe), 32'd0);
    chk("reset_alWe", 0, 32'(alWe), 32'd0);
    chk("reset_rel", 0, 32'(mshrRelease), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Basic load writeback on lane 0
    step(); idle();
    set_lane(0, 7'd5, 32'hDEADBEEF, 1, 1, 6'd3, 2'b01, 1, 0, 0, 1'b0);
    step(); idle();
    #1;
    chk("d45_rfWe", 0, 32'(rfWe[0]), 32'd1);
    chk("d45_rfAddr", 0, 32'(rfAddr[0 +: PREG_W]), 32'd5);
    chk("d45_rfData", 0, rfData[0 +: 32], 32'hDEADBEEF);
    chk("d45_alWe", 0, 32'(alWe[0]), 32'd1);
    chk("d45_alPtr", 0, 32'(alPtr[0 +: AL_W]), 32'd3);
    chk("d45_alState", 0, 32'(alState[0 +: 2]), 32'd1);

    // Three stalled cycles then exactly one pulse
    step(); idle();
    set_lane(0, 7'd9, 32'h1234, 1, 1, 6'd7, 2'b00, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); idle(); stall = 1;
      #1 chk("d46_stall_rfWe", 0, 32'(rfWe[0]), 32'd0);
    end
    step(); idle();
    #1;
    chk("d46_rfWe", 0, 32'(rfWe[0]), 32'd1);
    chk("d46_alWe", 0, 32'(alWe[0]), 32'd1);
    step(); idle();
    #1 chk("d46_once", 0, 32'(alWe[0]), 32'd0);

    // Wrapped recovery range
    step(); idle();
    set_lane(0, 7'd1, 32'h0, 0, 0, 6'd62, 2'b00, 0, 0, 0, 1'b0);
    set_lane(1, 7'd2, 32'h0, 0, 0, 6'd10, 2'b00, 0, 0, 0, 1'b0);
    step(); idle();
    toRecovery = 1; flushHead = 6'd60; flushTail = 6'd2;
    #1;
    chk("d47_lane0", 0, 32'(alWe[0]), 32'd0);
    chk("d47_lane1", 1, 32'(alWe[1]), 32'd1);

    // Store-forward miss load releasing its MSHR
    step(); idle();
    set_lane(0, 7'd4, 32'hCAFE, 1, 1, 6'd20, 2'b01, 1, 1, 1, 1'b1);
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
    sf_before = perfSfMiss;
`endif
    step(); idle();
    #1;
    chk("d48_rfWe", 0, 32'(rfWe[0]), 32'd0);
    chk("d48_alState", 0, 32'(alState[0 +: 2]), 32'd3);
    chk("d48_rel", 0, 32'(mshrRelease[0]), 32'd1);
    chk("d48_relId", 0, 32'(mshrRelId[0 +: MSHR_W]), 32'd1);
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
    step();
    chk("d48_perf", 0, perfSfMiss, sf_before + 32'd1);
`endif

    // flushAll with empty range, then empty range alone
    step(); idle();
    set_lane(0, 7'd1, 32'h0, 0, 0, 6'd5, 2'b00, 0, 0, 0, 1'b0);
    set_lane(1, 7'd2, 32'h0, 0, 0, 6'd6, 2'b00, 0, 0, 0, 1'b0);
    step(); idle();
    flushAll = 1; flushHead = 6'd5; flushTail = 6'd5;
    #1 chk("d50_all", 0, 32'(alWe), 32'd0);
    step(); idle();
    set_lane(0, 7'd1, 32'h0, 0, 0, 6'd5, 2'b00, 0, 0, 0, 1'b0);
    set_lane(1, 7'd2, 32'h0, 0, 0, 6'd6, 2'b00, 0, 0, 0, 1'b0);
    step(); idle();
    toRecovery = 1; flushHead = 6'd5; flushTail = 6'd5;
    #1 chk("d50_empty", 0, 32'(alWe), 32'd3);

    // Asynchronous reset with both lanes valid
    step(); idle();
    set_lane(0, 7'd3, 32'h55, 1, 1, 6'd1, 2'b00, 1, 0, 0, 1'b0);
    set_lane(1, 7'd4, 32'h66, 1, 1, 6'd2, 2'b00, 1, 0, 0, 1'b0);
    step(); idle(); stall = 1;
    #1 rst = 1;
    #1;
    chk("d49_rfWe", 0, 32'(rfWe), 32'd0);
    chk("d49_alWe", 0, 32'(alWe), 32'd0);
`ifdef RSD_MEM_WB_PERF_COUNTER_EN
    chk("d49_perfLoad", 0, perfLoadWb, 32'd0);
    chk("d49_perfSf", 0, perfSfMiss, 32'd0);
`endif
    rst = 0;
    step(); idle();
    #1 chk("d49_after", 0, 32'(alWe), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_in();
    end
    step(); idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_register_write_stage.md
MEMORY_REGISTER_WRITE_STAGE -- requirements
Module: memory_register_write_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter LANES, default 2, meaning the number of memory issue lanes.
REQ-003 The block SHALL have parameter AL_W, default 6, meaning the active-list pointer width.
REQ-004 The block SHALL have parameter PREG_W, default 7, meaning the physical register index width.
REQ-005 The block SHALL have parameter MSHR_W, default 1, meaning the MSHR id width.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port stall, input, 1 bit: backend stall; hold pipe register.
REQ-009 Port clear, input, 1 bit: backend clear; invalidate captured ops.
REQ-010 Port inValid, input, LANES bits: lane valid from the memory access stage.
REQ-011 Port inRegValid, input, LANES bits: result data valid.
REQ-012 Port inData, input, LANES*32 bits: result data.
REQ-013 Port inDst, input, LANES*PREG_W bits: destination physical register.
REQ-014 Port inWriteReg, input, LANES bits: op writes a register.
REQ-015 Port inAlPtr, input, LANES*AL_W bits: active-list pointer.
REQ-016 Port inExecState, input, LANES*2 bits: execution state.
REQ-017 Port inIsLoad, input, LANES bits: op is a load.
REQ-018 Port inSfMiss, input, LANES bits: store-forward miss.
REQ-019 Port inHasMshr, input, LANES bits: op holds an allocated MSHR.
REQ-020 Port inMshrId, input, LANES*MSHR_W bits: id of that MSHR.
REQ-021 Port toRecovery, input, 1 bit: selective flush active.
REQ-022 Ports flushHead and flushTail, input, AL_W bits each: flush range [head, tail).
REQ-023 Port flushAll, input, 1 bit: flush every in-flight op.
REQ-024 Ports rfWe (LANES), rfAddr (LANES*PREG_W) and rfData (LANES*32), output: register file write.
REQ-025 Ports alWe (LANES), alPtr (LANES*AL_W) and alState (LANES*2), output: active-list completion.
REQ-026 Ports mshrRelease (LANES) and mshrRelId (LANES*MSHR_W), output: MSHR release.

Function
REQ-027 The block SHALL capture all in* signals into a per-lane pipe register at each posedge when !stall, and SHALL hold that register when stall=1.
REQ-028 On capture, the block SHALL write valid[l] as inValid[l] && !clear.
REQ-029 The block SHALL compute flush[l] combinationally from the registered pointer p, as follows:
  - flush[l]=1 when flushAll=1.
  - When toRecovery=1 and head<tail: flush[l] = head<=p<tail.
  - When toRecovery=1 and head>tail (wrapped range): flush[l] = p>=head || p<tail.
  - When toRecovery=1 and head==tail with flushAll=0: flush[l]=0 (empty range).
  - Otherwise flush[l]=0.
REQ-030 The block SHALL compute the commit condition fire[l] = valid[l] && !stall && !flush[l].
REQ-031 The block SHALL assert rfWe[l] = fire[l] && writeReg[l] && regValid[l], and SHALL drive rfAddr and rfData from the register.
REQ-032 The block SHALL assert alWe[l] = fire[l], and SHALL drive alPtr from the register.
REQ-033 The block SHALL drive alState as 2'b11 when isLoad && sfMiss, and otherwise as the registered execState.
REQ-034 On a load with sfMiss, the block SHALL assert rfWe=0 regardless of regValid.
REQ-035 The block SHALL assert mshrRelease[l] = fire[l] && isLoad[l] && hasMshr[l], and SHALL drive mshrRelId from the register.
REQ-036 Latency SHALL be one cycle: an op captured at edge N drives its outputs during the cycle that follows edge N.
REQ-037 During stall, all output strobes SHALL be 0 and the op SHALL remain held; it fires once, in the first non-stall cycle.
REQ-038 A flushed op SHALL produce no strobes; its valid bit SHALL be overwritten at the next capture.
REQ-039 Lanes SHALL be independent; simultaneous fires on all lanes are legal, with no cross-lane ordering.

Reset
REQ-040 While rst=1, the block SHALL asynchronously clear all valid bits, and rfWe, alWe and mshrRelease SHALL be 0.
REQ-041 Payload fields SHALL not be reset; their values are don't-care while valid=0.
REQ-042 Assertion of rst mid-stall SHALL drop the held op, and no strobe SHALL fire for it after reset.

Configuration
REQ-043 When RSD_MEM_WB_PERF_COUNTER_EN is defined, the block SHALL add two 32-bit wrapping output counters, async-reset to 0:
  - perfLoadWb counts rfWe on loads, summed over all lanes per cycle.
  - perfSfMiss counts fired sfMiss loads.
REQ-044 When RSD_MEM_WB_PERF_COUNTER_EN is undefined, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-045 Lane0 load, dst=5, data=0xDEADBEEF, regValid=1, alPtr=3 -> next cycle rfWe0=1, rfAddr0=5, rfData0=0xDEADBEEF, alWe0=1, alPtr0=3, alState0=execState.
REQ-046 Op held with stall=1 for 3 cycles -> no strobes in those cycles, then exactly one rfWe/alWe pulse when stall drops.
REQ-047 toRecovery=1, head=60, tail=2 (AL_W=6), lane ptrs 62 and 10 -> lane0 suppressed, lane1 fires.
REQ-048 Load with sfMiss=1, hasMshr=1, mshrId=1 -> rfWe=0, alState=2'b11, mshrRelease=1, mshrRelId=1; with the macro defined, perfSfMiss increments by 1.
REQ-049 rst pulsed asynchronously mid-cycle while both lanes are valid -> strobes drop immediately; no fire after release; counters read 0.
REQ-050 flushAll=1 with head==tail -> both lanes suppressed; toRecovery=1, head==tail, flushAll=0 -> both lanes fire.
